// File: rtl/fib_request_sequencer.sv
// Request-driven front end for a 32-bit Fibonacci generator: restarts the generator,
// steps it n times, captures F(n) and returns it over a valid/ready response channel.
module fib_request_sequencer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned MAX_INDEX = 47
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_n,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              gen_rst,
  output logic              gen_enable,
  input  logic [DATA_W-1:0] fib_in
);

  localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(MAX_INDEX);
  localparam logic [IDX_W-1:0] One    = IDX_W'(1);

  typedef enum logic [2:0] {StIdle, StClear, StStep, StCapture, StResp} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cnt;

  assign req_ready = (state == StIdle);

  // gen_rst/gen_enable are loaded with the value they must carry in the state being entered,
  // so they track the state register without any input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StIdle;
      idx        <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      gen_rst    <= 1'b1;
      gen_enable <= 1'b0;
    end else begin
      gen_rst    <= 1'b0;
      gen_enable <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            idx <= req_n;
            cnt <= req_n;
            if (req_n > MaxIdx) begin
              state      <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= '0;
            end else begin
              state   <= StClear;
              gen_rst <= 1'b1;
            end
          end
        end
        StClear: begin
          if (idx == '0) begin
            state <= StCapture;
          end else begin
            state      <= StStep;
            gen_enable <= 1'b1;
          end
        end
        StStep: begin
          cnt <= cnt - One;
          if (cnt == One) begin
            state <= StCapture;
          end else begin
            gen_enable <= 1'b1;
          end
        end
        StCapture: begin
          resp_data  <= fib_in;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_request_sequencer.sv
// Directed bench for fib_request_sequencer with a behavioural Fibonacci generator attached.
module tb_fib_request_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_n;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        gen_rst;
  logic        gen_enable;
  logic [31:0] fib_in;

  int n_cmp  = 0;
  int n_fail = 0;

  fib_request_sequencer #(
    .DATA_W   (32),
    .IDX_W    (6),
    .MAX_INDEX(47)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_n     (req_n),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .gen_rst   (gen_rst),
    .gen_enable(gen_enable),
    .fib_in    (fib_in)
  );

  always #5 clk = ~clk;

  // Generator model: reset to F(0) with prev = 1, one step per enabled cycle.
  logic [31:0] g_prev;
  always @(posedge clk) begin
    if (gen_rst) begin
      fib_in <= 32'd0;
      g_prev <= 32'd1;
    end else if (gen_enable) begin
      fib_in <= fib_in + g_prev;
      g_prev <= fib_in;
    end
  end

  int en_cnt   = 0;
  int grst_cnt = 0;
  always @(negedge clk) begin
    if (gen_enable) en_cnt++;
    if (gen_rst) grst_cnt++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and wait for resp_valid; lat counts cycles with acceptance cycle as 1.
  task automatic do_req(input int n, output logic [31:0] data, output logic err,
                        output int lat, output int ens, output int rsts);
    int w;
    int base_en;
    int base_rst;
    @(negedge clk);
    req_valid = 1'b1;
    req_n     = 6'(n);
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    base_en   = en_cnt;
    base_rst  = grst_cnt;
    lat       = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    data = resp_data;
    err  = resp_err;
    ens  = en_cnt - base_en;
    rsts = grst_cnt - base_rst;
  endtask

  typedef struct {
    int          n;
    logic [31:0] data;
    logic        err;
    int          lat;
    int          ens;
    int          rsts;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          ens;
    int          rsts;
    int          seen;
    int          w;
    int          stray;

    vecs[0] = '{10, 32'd55,         1'b0, 13, 10, 1};
    vecs[1] = '{0,  32'd0,          1'b0, 3,  0,  1};
    vecs[2] = '{1,  32'd1,          1'b0, 4,  1,  1};
    vecs[3] = '{2,  32'd1,          1'b0, 5,  2,  1};
    vecs[4] = '{47, 32'd2971215073, 1'b0, 50, 47, 1};
    vecs[5] = '{48, 32'd0,          1'b1, 1,  0,  0};
    vecs[6] = '{63, 32'd0,          1'b1, 1,  0,  0};
    vecs[7] = '{7,  32'd13,         1'b0, 10, 7,  1};

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_n      = '0;
    resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gen_rst", gen_rst, 1);
    check("rst_gen_enable", gen_enable, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_err", resp_err, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_gen_rst", gen_rst, 0);

    for (int i = 0; i < 8; i++) begin
      do_req(vecs[i].n, d, e, lat, ens, rsts);
      check($sformatf("v%0d_data", vecs[i].n), d, vecs[i].data);
      check($sformatf("v%0d_err", vecs[i].n), e, vecs[i].err);
      check($sformatf("v%0d_latency", vecs[i].n), lat, vecs[i].lat);
      check($sformatf("v%0d_enable_cycles", vecs[i].n), ens, vecs[i].ens);
      check($sformatf("v%0d_gen_rst_cycles", vecs[i].n), rsts, vecs[i].rsts);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_resp_consumed", vecs[i].n), resp_valid, 0);
    end

    // Backpressure: response must hold while a new request waits.
    resp_ready = 1'b0;
    do_req(20, d, e, lat, ens, rsts);
    check("bp_data", d, 6765);
    check("bp_latency", lat, 23);
    @(negedge clk);
    req_valid = 1'b1;
    req_n     = 6'd5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", k), resp_valid, 1);
      check($sformatf("bp_hold_data_%0d", k), resp_data, 6765);
      check($sformatf("bp_req_ready_%0d", k), req_ready, 0);
    end
    resp_ready = 1'b1;
    do_req(5, d, e, lat, ens, rsts);
    check("bp_next_data", d, 5);
    check("bp_next_latency", lat, 8);
    @(posedge clk);
    #1;

    // Reset in the 4th STEP cycle of n = 30.
    @(negedge clk);
    req_valid = 1'b1;
    req_n     = 6'd30;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    seen = 0;
    w    = 0;
    while (seen < 4 && w < 100) begin
      @(negedge clk);
      if (gen_enable) seen++;
      w++;
    end
    check("midrst_step_reached", seen, 4);
    rst = 1'b0;
    #1;
    check("midrst_gen_enable", gen_enable, 0);
    check("midrst_gen_rst", gen_rst, 1);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    stray = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    check("midrst_no_response", stray, 0);
    do_req(12, d, e, lat, ens, rsts);
    check("midrst_after_data", d, 144);
    check("midrst_after_latency", lat, 15);
    check("midrst_after_enables", ens, 12);
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
